// File: rtl/broadcast_fork_pkg.sv
// Shared defaults for the broadcast fork slice.
package broadcast_fork_pkg;

    localparam int unsigned DefaultNumElem   = 4;
    localparam int unsigned DefaultDataWidth = 64;

endpackage

// File: rtl/and_reduction.sv
// Bitwise AND across NUM_ELEM packed elements of ELEM_WIDTH bits each.
module and_reduction #(
    parameter int unsigned NUM_ELEM   = 4,
    parameter int unsigned ELEM_WIDTH = 1
) (
    input  logic [NUM_ELEM*ELEM_WIDTH-1:0] data_i,
    output logic [ELEM_WIDTH-1:0]          data_o
);

    always_comb begin
        data_o = '1;
        for (int unsigned i = 0; i < NUM_ELEM; i++) begin
            data_o &= data_i[i*ELEM_WIDTH +: ELEM_WIDTH];
        end
    end

endmodule

// File: rtl/broadcast_fork.sv
// Single-entry registered broadcast: one upstream word is held until every
// consumer has taken it exactly once.
module broadcast_fork
    import broadcast_fork_pkg::*;
#(
    parameter int unsigned NUM_ELEM   = DefaultNumElem,
    parameter int unsigned DATA_WIDTH = DefaultDataWidth
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  data_valid_i,
    output logic                  data_ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [NUM_ELEM-1:0]   data_valid_o,
    input  logic [NUM_ELEM-1:0]   data_ready_i
);

    logic                  full_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [NUM_ELEM-1:0]   pending_q;
    logic [NUM_ELEM-1:0]   done;
    logic                  all_done;
    logic                  in_hs;

    and_reduction #(
        .NUM_ELEM   (NUM_ELEM),
        .ELEM_WIDTH (1)
    ) u_all_done (
        .data_i (done),
        .data_o (all_done)
    );

    // Ready depends on consumer readies so a retiring entry can be replaced without a bubble.
    always_comb begin
        done         = ~pending_q | data_ready_i;
        data_valid_o = {NUM_ELEM{full_q}} & pending_q;
        data_ready_o = ~flush_i & (~full_q | all_done);
        in_hs        = data_valid_i & data_ready_o;
        data_o       = data_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush_i) begin
            full_q    <= 1'b0;
            pending_q <= '0;
        end else if (in_hs) begin
            full_q    <= 1'b1;
            data_q    <= data_i;
            pending_q <= '1;
        end else if (full_q && all_done) begin
            full_q    <= 1'b0;
            pending_q <= '0;
        end else if (full_q) begin
            pending_q <= pending_q & ~data_ready_i;
        end
    end

endmodule
